// File: rtl/shader_pkg.sv
// Shared types and constants for the triangle loader and the VGA/shader vertex map.
// TRI_LOADER_KICK_EN adds the KICK state used to write the kick register after v3y.
package shader_pkg;

  // One triangle as it travels through the loader; v1x occupies the LSBs.
  typedef struct packed {
    logic [15:0] v3y;
    logic [15:0] v3x;
    logic [15:0] v2y;
    logic [15:0] v2x;
    logic [15:0] v1y;
    logic [15:0] v1x;
  } tri_t;

  // Word offsets of the vertex registers relative to the peripheral base.
  localparam logic [2:0] REG_V1X  = 3'd0;
  localparam logic [2:0] REG_V1Y  = 3'd1;
  localparam logic [2:0] REG_V2X  = 3'd2;
  localparam logic [2:0] REG_V2Y  = 3'd3;
  localparam logic [2:0] REG_V3X  = 3'd4;
  localparam logic [2:0] REG_V3Y  = 3'd5;
  localparam logic [2:0] REG_KICK = 3'd6;

  localparam logic [15:0] KICK_DATA = 16'h0001;

`ifdef TRI_LOADER_KICK_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_KICK
  } loader_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE
  } loader_state_t;
`endif

  // Selects the 16-bit word of a triangle that belongs at a given register offset.
  function automatic logic [15:0] tri_word(input tri_t t, input logic [2:0] idx);
    logic [15:0] word;
    case (idx)
      REG_V1X: word = t.v1x;
      REG_V1Y: word = t.v1y;
      REG_V2X: word = t.v2x;
      REG_V2Y: word = t.v2y;
      REG_V3X: word = t.v3x;
      REG_V3Y: word = t.v3y;
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/triangle_loader_if.sv
// Bundles the triangle intake stream and the Avalon-MM write port of the loader.
// The master modport is the loader's view; the slave modport is the view of the
// environment around it (geometry source plus the peripheral's slave port).
interface triangle_loader_if;

  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_tri;

  logic [7:0]  avm_address;
  logic [15:0] avm_writedata;
  logic        avm_write;
  logic        avm_chipselect;
  logic        avm_waitrequest;

  modport master (
    input  in_valid,
    output in_ready,
    input  in_tri,
    output avm_address,
    output avm_writedata,
    output avm_write,
    output avm_chipselect,
    input  avm_waitrequest
  );

  modport slave (
    output in_valid,
    input  in_ready,
    output in_tri,
    input  avm_address,
    input  avm_writedata,
    input  avm_write,
    input  avm_chipselect,
    output avm_waitrequest
  );

endinterface

// File: rtl/tri_fifo.sv
// Synchronous DEPTH-entry triangle FIFO. Pointers carry one extra wrap bit and
// index storage through their low bits, so DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module tri_fifo
  import shader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  tri_t push_data,
  input  logic pop,
  output tri_t pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  tri_t           mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Advance the pointers; the extra top bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/triangle_loader.sv
// Avalon-MM write initiator: takes whole triangles from a valid/ready stream into
// a small FIFO and writes each one as six words to the vertex registers at
// BASE_ADDR..BASE_ADDR+5 (addresses wrap at 8 bits).
// Optional feature macro: TRI_LOADER_KICK_EN appends a write of 16'h0001 to
// BASE_ADDR+6 after every triangle; tri_count then counts on that write instead.
module triangle_loader
  import shader_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] BASE_ADDR = 8'd0
) (
  input  logic               clk,
  input  logic               reset,
  triangle_loader_if.master  bus,
  output logic               busy,
  output logic [15:0]        tri_count
);

  loader_state_t state, state_next;
  logic [2:0]    idx, idx_next;
  tri_t          hold, hold_next;
  logic [7:0]    addr_q, addr_next;
  logic [15:0]   data_q, data_next;
  logic          write_q, write_next;
  logic [15:0]   count_next;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  tri_t          fifo_head;
  logic          accepted;
  logic [2:0]    idx_inc;

  tri_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.in_valid),
    .push_data (tri_t'(bus.in_tri)),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.in_ready       = !fifo_full;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = data_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_chipselect = write_q;
  assign busy               = (state != ST_IDLE) || !fifo_empty;

  assign accepted = write_q && !bus.avm_waitrequest;
  assign idx_inc  = idx + 3'd1;

  // Sequencer: picks up a triangle, then presents the next word of the Avalon
  // write one cycle ahead so every bus output comes straight from a flop.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    hold_next  = hold;
    addr_next  = addr_q;
    data_next  = data_q;
    write_next = 1'b0;
    count_next = tri_count;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          hold_next  = fifo_head;
          idx_next   = REG_V1X;
          addr_next  = BASE_ADDR + {5'd0, REG_V1X};
          data_next  = tri_word(fifo_head, REG_V1X);
          write_next = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        write_next = 1'b1;
        if (accepted) begin
          if (idx == REG_V3Y) begin
`ifdef TRI_LOADER_KICK_EN
            addr_next  = BASE_ADDR + {5'd0, REG_KICK};
            data_next  = KICK_DATA;
            state_next = ST_KICK;
`else
            write_next = 1'b0;
            count_next = tri_count + 16'd1;
            state_next = ST_IDLE;
`endif
          end else begin
            idx_next  = idx_inc;
            addr_next = BASE_ADDR + {5'd0, idx_inc};
            data_next = tri_word(hold, idx_inc);
          end
        end
      end
`ifdef TRI_LOADER_KICK_EN
      ST_KICK: begin
        write_next = 1'b1;
        if (accepted) begin
          write_next = 1'b0;
          count_next = tri_count + 16'd1;
          state_next = ST_IDLE;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Register state, the in-flight triangle and all Avalon outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= REG_V1X;
      hold      <= '0;
      addr_q    <= 8'd0;
      data_q    <= 16'd0;
      write_q   <= 1'b0;
      tri_count <= 16'd0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      hold      <= hold_next;
      addr_q    <= addr_next;
      data_q    <= data_next;
      write_q   <= write_next;
      tri_count <= count_next;
    end
  end

endmodule

// File: tb/tb_triangle_loader.sv
// Scoreboard bench for triangle_loader. Accepted triangles are expanded into the
// expected Avalon write sequence by a simple word-slicing model; a monitor checks
// every bus cycle and the completed-triangle count against that queue.
module tb_triangle_loader;
  import shader_pkg::*;

  localparam int         DEPTH = 4;
  localparam logic [7:0] BASE  = 8'd252;
`ifdef TRI_LOADER_KICK_EN
  localparam int WPT     = 7;
  localparam bit KICK_EN = 1'b1;
`else
  localparam int WPT     = 6;
  localparam bit KICK_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    bit          last;
  } exp_write_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [15:0] tri_count;

  int checks = 0;
  int passes = 0;

  exp_write_t exp_q[$];
  int         exp_count = 0;
  int         write_cycles = 0;
  int         accepts = 0;
  int         slave_mode = 1;
  logic [7:0] stall_addr = 8'd0;
  int         script_stalls = 0;

  triangle_loader_if bus();

  triangle_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .tri_count (tri_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
  endtask

  function automatic logic [95:0] rand_tri();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: word i of a triangle goes to (BASE + i) mod 256.
  function automatic void model_push(input logic [95:0] t);
    exp_write_t e;
    for (int i = 0; i < 6; i++) begin
      e.addr = 8'((int'(BASE) + i) % 256);
      e.data = t[16*i +: 16];
      e.last = (i == 5) && !KICK_EN;
      exp_q.push_back(e);
    end
    if (KICK_EN) begin
      e.addr = 8'((int'(BASE) + 6) % 256);
      e.data = 16'h0001;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  // Input side of the scoreboard: every handshake queues its expected writes.
  always @(negedge clk) begin
    if (!reset && bus.in_valid && bus.in_ready) model_push(bus.in_tri);
  end

  // Output side: every write cycle must show the head of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_count = 0;
    end else begin
      check_output("tri_count", {16'd0, tri_count}, exp_count);
      if (bus.avm_write) begin
        write_cycles++;
        check_output("chipselect_on_write", {31'd0, bus.avm_chipselect}, 1);
        if (exp_q.size() == 0) begin
          check_output("unexpected_write_addr", {24'd0, bus.avm_address}, 32'hFFFF_FFFF);
        end else begin
          check_output("write_addr", {24'd0, bus.avm_address}, {24'd0, exp_q[0].addr});
          check_output("write_data", {16'd0, bus.avm_writedata}, {16'd0, exp_q[0].data});
          if (!bus.avm_waitrequest) begin
            if (exp_q[0].last) exp_count++;
            void'(exp_q.pop_front());
          end
        end
        if (!bus.avm_waitrequest) accepts++;
      end else begin
        check_output("chipselect_idle", {31'd0, bus.avm_chipselect}, 0);
      end
    end
  end

  // Slave model: 0 random stalls, 1 never stalls, 2 always stalls, 3 stalls three cycles on stall_addr.
  always @(posedge clk) begin
    #1;
    if (slave_mode == 3 && bus.avm_write && bus.avm_address == stall_addr && script_stalls < 3) begin
      bus.avm_waitrequest = 1'b1;
      script_stalls++;
    end else if (slave_mode == 2) begin
      bus.avm_waitrequest = 1'b1;
    end else if (slave_mode == 0) begin
      bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
    end else begin
      bus.avm_waitrequest = 1'b0;
    end
    if (slave_mode != 3) script_stalls = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [95:0] t, input int max_wait, output bit got);
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_tri   = t;
    for (int n = 0; n < max_wait; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (got) step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check_output("idle_reached", {31'd0, done}, 1);
    step();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    int tri_total;
    int acc;
    int w0;
    int a0;
    int first_w;
    int last_w;
    logic [95:0] held;

    bus.in_valid = 1'b0;
    bus.in_tri   = '0;
    tri_total    = 0;

    // Reset values.
    repeat (3) step();
    @(negedge clk);
    check_output("rst_write", {31'd0, bus.avm_write}, 0);
    check_output("rst_chipselect", {31'd0, bus.avm_chipselect}, 0);
    check_output("rst_address", {24'd0, bus.avm_address}, 0);
    check_output("rst_writedata", {16'd0, bus.avm_writedata}, 0);
    check_output("rst_in_ready", {31'd0, bus.in_ready}, 1);
    check_output("rst_busy", {31'd0, busy}, 0);
    check_output("rst_tri_count", {16'd0, tri_count}, 0);
    step();
    reset = 1'b0;
    step();

    // Single triangle {1..6}: first write two cycles after the push cycle.
    $display("[TB] single triangle and latency");
    slave_mode = 1;
    w0 = write_cycles;
    bus.in_valid = 1'b1;
    bus.in_tri   = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    @(negedge clk);
    check_output("push_ready", {31'd0, bus.in_ready}, 1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("latency_t1_write", {31'd0, bus.avm_write}, 0);
    @(negedge clk);
    check_output("latency_t2_write", {31'd0, bus.avm_write}, 1);
    check_output("latency_t2_addr", {24'd0, bus.avm_address}, {24'd0, BASE});
    check_output("latency_t2_data", {16'd0, bus.avm_writedata}, 1);
    step();
    tri_total++;
    wait_idle(100);
    check_output("single_tri_count", {16'd0, tri_count}, tri_total);
    check_output("single_busy", {31'd0, busy}, 0);
    check_output("single_write_cycles", write_cycles - w0, WPT);

    // Two triangles back to back: one idle cycle between their write bursts.
    $display("[TB] back-to-back spacing");
    apply_stimulus(rand_tri(), 10, got);
    tri_total += int'(got);
    apply_stimulus(rand_tri(), 10, got);
    tri_total += int'(got);
    first_w = -1;
    last_w  = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.avm_write) begin
        if (first_w < 0) first_w = n;
        last_w = n;
      end
    end
    check_output("b2b_span", last_w - first_w + 1, 2 * WPT + 1);
    step();
    wait_idle(100);
    check_output("b2b_tri_count", {16'd0, tri_count}, tri_total);

    // Three waitrequest cycles on the v2x write add exactly three cycles.
    $display("[TB] waitrequest on v2x");
    stall_addr = 8'((int'(BASE) + 2) % 256);
    slave_mode = 3;
    w0 = write_cycles;
    a0 = accepts;
    apply_stimulus(rand_tri(), 10, got);
    tri_total += int'(got);
    wait_idle(100);
    slave_mode = 1;
    check_output("stall_write_cycles", write_cycles - w0, WPT + 3);
    check_output("stall_accepts", accepts - a0, WPT);

    // FIFO fill with the slave stalled: DEPTH queued plus one in the hold register.
    $display("[TB] fifo full behaviour");
    slave_mode = 2;
    acc = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      apply_stimulus(rand_tri(), 1, got);
      if (!got) break;
      acc++;
    end
    tri_total += acc;
    check_output("full_accept_count", acc, DEPTH + 1);
    held = rand_tri();
    bus.in_valid = 1'b1;
    bus.in_tri   = held;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("full_in_ready", {31'd0, bus.in_ready}, 0);
      step();
    end
    slave_mode = 0;
    apply_stimulus(held, 300, got);
    tri_total += int'(got);
    check_output("full_late_accept", {31'd0, got}, 1);
    wait_idle(500);
    check_output("full_tri_count", {16'd0, tri_count}, tri_total);

    // Random traffic with random stalls and random gaps.
    $display("[TB] random traffic");
    slave_mode = 0;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(rand_tri(), 500, got);
      tri_total += int'(got);
      repeat ($urandom_range(0, 8)) step();
    end
    wait_idle(2000);
    check_output("random_tri_count", {16'd0, tri_count}, tri_total);

    // Reset after the third write of a triangle discards everything.
    $display("[TB] reset mid-triangle");
    slave_mode = 1;
    a0 = accepts;
    apply_stimulus(rand_tri(), 10, got);
    apply_stimulus(rand_tri(), 10, got);
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (accepts - a0 >= 3) begin
        got = 1'b1;
        break;
      end
    end
    check_output("reset_third_accept_seen", {31'd0, got}, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tri_total = 0;
    @(negedge clk);
    check_output("reset_write_low", {31'd0, bus.avm_write}, 0);
    check_output("reset_in_ready", {31'd0, bus.in_ready}, 1);
    check_output("reset_busy", {31'd0, busy}, 0);
    check_output("reset_tri_count", {16'd0, tri_count}, 0);
    a0 = accepts;
    w0 = write_cycles;
    repeat (20) step();
    @(negedge clk);
    check_output("reset_no_writes", write_cycles - w0, 0);
    check_output("reset_no_accepts", accepts - a0, 0);
    check_output("reset_final_busy", {31'd0, busy}, 0);
    check_output("reset_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/triangle_loader.md
# triangle_loader

Avalon-MM write initiator that feeds the VGA/shader peripheral's vertex registers. It accepts whole triangles (three 16-bit x/y vertex pairs) on a valid/ready stream into a small FIFO. For each triangle it issues six single-word Avalon writes to register offsets 0..5 (v1x, v1y, v2x, v2y, v3x, v3y), honouring waitrequest. It sits between the geometry source (CPU-side DMA or test pattern generator) and the peripheral's slave port.

## Interface
- DEPTH, 4: triangle FIFO entries; power of two, ≥2
- BASE_ADDR, 8'd0: word address of the v1x register in the slave's map
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  triangle presented
- in_ready  out  1  FIFO can accept a triangle
- in_tri  in  96  packed {v3y, v3x, v2y, v2x, v1y, v1x}; v1x in bits [15:0]
- avm_address  out  8  word address
- avm_writedata  out  16  write data
- avm_write  out  1  write request
- avm_chipselect  out  1  asserted together with avm_write
- avm_waitrequest  in  1  slave stall
- busy  out  1  FIFO non-empty or transfer in progress
- tri_count  out  16  completed triangles, wraps modulo 2^16

## Operation
- The FIFO holds DEPTH triangles.
  - Push on in_valid && in_ready.
  - in_ready = !full, computed from registered state only. A push while full is refused, even in a cycle where a pop occurs.
- FSM states: IDLE, WRITE, KICK (KICK exists only with the kick feature).
- IDLE
  - If the FIFO is not empty: pop the head into the 96-bit hold register, set idx=0, go to WRITE.
  - Otherwise stay in IDLE.
- WRITE
  - Drive avm_write=avm_chipselect=1.
  - avm_address = BASE_ADDR+idx, truncated to 8 bits (wraps past 255).
  - avm_writedata = hold word idx.
  - A write is accepted in a cycle with avm_write && !avm_waitrequest.
  - On acceptance with idx<5: idx++.
  - On acceptance with idx==5: go to KICK if enabled, else go to IDLE and increment tri_count.
  - Address and data stay stable while waitrequest is high.
- The hold register is never modified mid-triangle. FIFO pushes during WRITE do not affect the triangle in flight.
- busy = (state!=IDLE) || !empty.
- Reset values: avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0, in_ready=1, busy=0, tri_count=0, FIFO empty, state IDLE, idx=0.
- Reset mid-transaction: the partial triangle and all FIFO contents are discarded, and avm_write is low from the next cycle. The slave keeps whatever registers were already written; this is accepted.

## Timing
- All Avalon outputs are registered.
- First write is presented 2 cycles after the push cycle:
  - push at cycle t
  - IDLE sees non-empty at t+1
  - avm_write high at t+2
- Zero wait states: 6 consecutive write cycles, then 1 IDLE cycle. That is 7 cycles per triangle, or 8 with kick.
- Each waitrequest cycle adds exactly one cycle.
- tri_count updates on the cycle after the final accepting edge.
- Maximum sustained intake: one triangle per 7 cycles. The FIFO absorbs bursts of up to DEPTH triangles.

## Configuration
- TRI_LOADER_KICK_EN
  - Defined: after the v3y write is accepted, state KICK issues one more write, address BASE_ADDR+6, data 16'h0001, same waitrequest rules. tri_count increments on acceptance of this write.
  - Undefined: KICK state and its logic are absent. The sequence ends at v3y and no address BASE_ADDR+6 write ever occurs.

## Structure
- shader_pkg holds:
  - tri_t packed struct (six 16-bit fields, v1x at LSBs)
  - register offset constants REG_V1X=0 through REG_V3Y=5, REG_KICK=6
  - loader state enum
- Sub-module tri_fifo: parameterised DEPTH × tri_t synchronous FIFO with push/pop/full/empty, pointer wrap by power-of-two masking. The loader instantiates it once.

## Test plan
- Single triangle {1,2,3,4,5,6}, waitrequest=0 → writes (addr,data) (0,1)(1,2)(2,3)(3,4)(4,5)(5,6) on consecutive cycles; tri_count=1; busy low after.
- Waitrequest high 3 cycles on the v2x write → address 2 and data 3 held 4 cycles; no duplicate or skipped write; total 9 cycles.
- Push 5 triangles back-to-back with DEPTH=4 and the slave stalled → in_ready low after the 4th is queued; the 5th accepted only after a pop; all 5 emitted in order; tri_count=5.
- BASE_ADDR=8'd254 → addresses 254, 255, 0, 1, 2, 3.
- Reset asserted after the 3rd write is accepted → avm_write=0 next cycle; FIFO empty; tri_count=0; no further writes.
- TRI_LOADER_KICK_EN defined → 7th write (6, 16'h0001) follows v3y; tri_count increments only after it is accepted.
